// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX/RX state encodings and frame-length helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  function automatic int unsigned frame_len(input int unsigned baud_div,
                                            input int unsigned data_bits,
                                            input int unsigned parity,
                                            input int unsigned stop_bits);
    return baud_div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; tc is high while enabled and the count has reached zero.
module uart_bit_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - WIDTH'(1);
  end

  assign tc = en && (count == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with TX holding register and RX data register.
// Optional internal loopback port is compiled in with UART_LOOPBACK_EN.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 868,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dbf,
  output logic                 tdf,
  output logic                 clk_div,
  output logic                 rdf,
  output logic                 rdc,
  output logic                 error,
  output logic                 perr,
  output logic                 ovr,
  output logic                 Txd,
  input  logic                 Rxd
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                 loopback
`endif
);

  localparam int unsigned   TW        = 16;
  localparam int unsigned   CW        = 4;
  localparam logic [TW-1:0] FULL_LOAD = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != PAR_NONE);
  localparam logic          ODD_INV   = (PARITY == PAR_ODD);

  logic wr_en, rd_en;
  assign wr_en = wr & ce & ~dbf;
  assign rd_en = rd & ce;

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_next;
  logic [DATA_BITS-1:0] tx_hold, tx_shift;
  logic [CW-1:0]        tx_cnt;
  logic [1:0]           tx_stop_cnt;
  logic                 tx_par, tx_take, tx_load, tx_tc, tx_line, txd_q, rx_in;

  uart_bit_timer #(.WIDTH(TW)) u_tx_timer (
    .clk(clk), .rst(rst), .en(tx_state != TX_IDLE), .load(tx_load),
    .load_val(FULL_LOAD), .tc(tx_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_take = 1'b0;
    tx_load = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      TX_IDLE: if (dbf) begin
        tx_take = 1'b1;
        tx_load = 1'b1;
        tx_next = TX_START;
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_tc) begin
          tx_load = 1'b1;
          tx_next = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_tc) begin
          tx_load = 1'b1;
          if (tx_cnt == LAST_DATA) tx_next = HAS_PAR ? TX_PAR : TX_STOP;
        end
      end
      TX_PAR: begin
        tx_line = tx_par;
        if (tx_tc) begin
          tx_load = 1'b1;
          tx_next = TX_STOP;
        end
      end
      TX_STOP: if (tx_tc) begin
        // A pending byte chains straight into the next start bit
        if (tx_stop_cnt != LAST_STOP) begin
          tx_load = 1'b1;
        end else if (dbf) begin
          tx_take = 1'b1;
          tx_load = 1'b1;
          tx_next = TX_START;
        end else begin
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dbf         <= 1'b0;
      tx_hold     <= '0;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_cnt      <= '0;
      tx_stop_cnt <= '0;
      txd_q       <= 1'b1;
    end else begin
      txd_q <= tx_line;
      if (tx_take) begin
        dbf         <= 1'b0;
        tx_shift    <= tx_hold;
        tx_par      <= (^tx_hold) ^ ODD_INV;
        tx_cnt      <= '0;
        tx_stop_cnt <= '0;
      end else begin
        if (wr_en) begin
          dbf     <= 1'b1;
          tx_hold <= din;
        end
        if (tx_tc && tx_state == TX_DATA) begin
          tx_shift <= tx_shift >> 1;
          tx_cnt   <= tx_cnt + CW'(1);
        end
        if (tx_tc && tx_state == TX_STOP) tx_stop_cnt <= tx_stop_cnt + 2'd1;
      end
    end
  end

  assign tdf     = (tx_state != TX_IDLE);
  assign clk_div = tx_tc;

`ifdef UART_LOOPBACK_EN
  assign Txd   = loopback ? 1'b1  : txd_q;
  assign rx_in = loopback ? txd_q : Rxd;
`else
  assign Txd   = txd_q;
  assign rx_in = Rxd;
`endif

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_next;
  logic [1:0]           rx_sync;
  logic                 rx_s, rx_load, rx_tc, rx_done, rx_par_bit, par_bad;
  logic [TW-1:0]        rx_load_val;
  logic [DATA_BITS-1:0] rx_shift;
  logic [CW-1:0]        rx_cnt;

  always_ff @(posedge clk) begin
    if (rst) rx_sync <= '1;
    else     rx_sync <= {rx_sync[0], rx_in};
  end
  assign rx_s = rx_sync[1];

  uart_bit_timer #(.WIDTH(TW)) u_rx_timer (
    .clk(clk), .rst(rst), .en(rx_state != RX_IDLE), .load(rx_load),
    .load_val(rx_load_val), .tc(rx_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next     = rx_state;
    rx_load     = 1'b0;
    rx_load_val = FULL_LOAD;
    rx_done     = 1'b0;
    case (rx_state)
      RX_IDLE: if (!rx_s) begin
        rx_load     = 1'b1;
        rx_load_val = HALF_LOAD;
        rx_next     = RX_START;
      end
      RX_START: if (rx_tc) begin
        if (rx_s) begin
          rx_next = RX_IDLE;
        end else begin
          rx_load = 1'b1;
          rx_next = RX_DATA;
        end
      end
      RX_DATA: if (rx_tc) begin
        rx_load = 1'b1;
        if (rx_cnt == LAST_DATA) rx_next = HAS_PAR ? RX_PAR : RX_STOP;
      end
      RX_PAR: if (rx_tc) begin
        rx_load = 1'b1;
        rx_next = RX_STOP;
      end
      RX_STOP: if (rx_tc) begin
        rx_done = 1'b1;
        rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign par_bad = HAS_PAR && (rx_par_bit != ((^rx_shift) ^ ODD_INV));
  assign rdc     = rx_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift   <= '0;
      rx_cnt     <= '0;
      rx_par_bit <= 1'b0;
      dout       <= '0;
      rdf        <= 1'b0;
      error      <= 1'b0;
      perr       <= 1'b0;
      ovr        <= 1'b0;
    end else begin
      if (rx_state == RX_START) rx_cnt <= '0;
      if (rx_tc && rx_state == RX_DATA) begin
        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
        rx_cnt   <= rx_cnt + CW'(1);
      end
      if (rx_tc && rx_state == RX_PAR) rx_par_bit <= rx_s;
      // Completion beats a simultaneous read: the read only frees room for the new byte
      if (rx_done) begin
        error <= (error & ~rd_en) | ~rx_s;
        perr  <= (perr & ~rd_en) | par_bad;
        if (!rdf || rd_en) begin
          dout <= rx_shift;
          rdf  <= 1'b1;
          ovr  <= ovr & ~rd_en;
        end else begin
          ovr <= 1'b1;
        end
      end else if (rd_en) begin
        rdf   <= 1'b0;
        error <= 1'b0;
        perr  <= 1'b0;
        ovr   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: three instances covering TX timing, RX error/overrun
// handling, loopback (PARITY=2), glitch rejection, back-to-back TX and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_core;
  import uart_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Unit A: BAUD_DIV=4, no parity; Rxd driven by the bench
  logic       a_rst, a_ce, a_wr, a_rd, a_rxd;
  logic [7:0] a_din, a_dout;
  logic       a_dbf, a_tdf, a_clk_div, a_rdf, a_rdc, a_error, a_perr, a_ovr, a_txd;
  // Unit B: BAUD_DIV=8, odd parity; Rxd driven by the bench
  logic       rst_bc, b_ce, b_wr, b_rd, b_rxd;
  logic [7:0] b_din, b_dout;
  logic       b_dbf, b_tdf, b_clk_div, b_rdf, b_rdc, b_error, b_perr, b_ovr, b_txd;
  // Unit C: BAUD_DIV=4, even parity; Txd wired back to Rxd
  logic       c_ce, c_wr, c_rd;
  logic [7:0] c_din, c_dout;
  logic       c_dbf, c_tdf, c_clk_div, c_rdf, c_rdc, c_error, c_perr, c_ovr, c_txd;

  uart_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst(a_rst), .ce(a_ce), .wr(a_wr), .din(a_din), .rd(a_rd), .dout(a_dout),
    .dbf(a_dbf), .tdf(a_tdf), .clk_div(a_clk_div), .rdf(a_rdf), .rdc(a_rdc),
    .error(a_error), .perr(a_perr), .ovr(a_ovr), .Txd(a_txd), .Rxd(a_rxd)
`ifdef UART_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  uart_core #(.BAUD_DIV(8), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rst(rst_bc), .ce(b_ce), .wr(b_wr), .din(b_din), .rd(b_rd), .dout(b_dout),
    .dbf(b_dbf), .tdf(b_tdf), .clk_div(b_clk_div), .rdf(b_rdf), .rdc(b_rdc),
    .error(b_error), .perr(b_perr), .ovr(b_ovr), .Txd(b_txd), .Rxd(b_rxd)
`ifdef UART_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  uart_core #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_c (
    .clk(clk), .rst(rst_bc), .ce(c_ce), .wr(c_wr), .din(c_din), .rd(c_rd), .dout(c_dout),
    .dbf(c_dbf), .tdf(c_tdf), .clk_div(c_clk_div), .rdf(c_rdf), .rdc(c_rdc),
    .error(c_error), .perr(c_perr), .ovr(c_ovr), .Txd(c_txd), .Rxd(c_txd)
`ifdef UART_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_rx(input int unit, input logic v);
    if (unit == 0) a_rxd = v;
    else           b_rxd = v;
  endtask

  // Drives bits[0] first, each for baud cycles, then returns the line to idle
  task automatic send_bits(input int unit, input logic [15:0] bits, input int nbits, input int baud);
    for (int i = 0; i < nbits; i++) begin
      drive_rx(unit, bits[i]);
      tick(baud);
    end
    drive_rx(unit, 1'b1);
  endtask

  function automatic logic [15:0] frame_b(input logic [7:0] d, input logic flip, input logic stop);
    return {5'b11111, stop, (~^d) ^ flip, d, 1'b0};
  endfunction

  task automatic host_wr(input int unit, input logic [7:0] d);
    case (unit)
      0: begin a_wr = 1'b1; a_ce = 1'b1; a_din = d; end
      1: begin b_wr = 1'b1; b_ce = 1'b1; b_din = d; end
      default: begin c_wr = 1'b1; c_ce = 1'b1; c_din = d; end
    endcase
    tick(1);
    a_wr = 1'b0; b_wr = 1'b0; c_wr = 1'b0;
    a_ce = 1'b0; b_ce = 1'b0; c_ce = 1'b0;
  endtask

  task automatic host_rd(input int unit);
    case (unit)
      0: begin a_rd = 1'b1; a_ce = 1'b1; end
      1: begin b_rd = 1'b1; b_ce = 1'b1; end
      default: begin c_rd = 1'b1; c_ce = 1'b1; end
    endcase
    tick(1);
    a_rd = 1'b0; b_rd = 1'b0; c_rd = 1'b0;
    a_ce = 1'b0; b_ce = 1'b0; c_ce = 1'b0;
  endtask

  // Writes 0xA5 to unit A and checks the serial waveform and strobe counts
  task automatic tx_a5_check(input string tag);
    logic [9:0] exp_seq;
    logic       txs [50];
    int         tdf_n, div_n, dbf_n;
    exp_seq = 10'b1101001010;
    tdf_n = 0; div_n = 0; dbf_n = 0;
    host_wr(0, 8'hA5);
    for (int n = 0; n < 50; n++) begin
      txs[n] = a_txd;
      tdf_n += int'(a_tdf);
      div_n += int'(a_clk_div);
      dbf_n += int'(a_dbf);
      tick(1);
    end
    chk($sformatf("%s_txd_pre", tag), txs[1], 1'b1);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s_txd_bit%0d", tag, i), txs[3 + 4*i], exp_seq[i]);
    chk($sformatf("%s_txd_post", tag), txs[49], 1'b1);
    chk($sformatf("%s_dbf_cycles", tag), dbf_n, 1);
    chk($sformatf("%s_tdf_cycles", tag), tdf_n, 40);
    chk($sformatf("%s_clk_div_pulses", tag), div_n, 10);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop;
    logic       rd_after;
    logic [7:0] e_dout;
    logic       e_rdf;
    logic       e_err;
    logic       e_perr;
    logic       e_ovr;
  } rx_vec_t;

  initial begin
    rx_vec_t     vec [5];
    logic [10:0] exp_b2b;
    logic        txs [200];
    int          cnt, tdf_n;
    logic        found;

    vec[0] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0};
    vec[1] = '{8'h11, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[2] = '{8'h22, 1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
    vec[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    a_rst = 1'b1; rst_bc = 1'b1;
    a_ce = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_din = '0; a_rxd = 1'b1;
    b_ce = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_din = '0; b_rxd = 1'b1;
    c_ce = 1'b0; c_wr = 1'b0; c_rd = 1'b0; c_din = '0;
    tick(3);
    a_rst = 1'b0; rst_bc = 1'b0;
    tick(1);

    chk("reset_a_status", {a_txd, a_dbf, a_tdf, a_clk_div, a_rdf, a_rdc, a_error, a_perr, a_ovr}, 9'h100);
    chk("reset_a_dout", a_dout, 8'h00);
    chk("reset_b_txd", b_txd, 1'b1);
    chk("reset_c_status", {c_txd, c_dbf, c_tdf, c_rdf, c_ovr}, 5'b10000);

    // Basic TX waveform
    tx_a5_check("tx_a5");

    // Write without chip enable is ignored
    c_wr = 1'b1; c_ce = 1'b0; c_din = 8'hFF;
    tick(1);
    c_wr = 1'b0;
    tick(2);
    chk("ce_gates_wr", {c_dbf, c_tdf}, 2'b00);

    // Loopback with even parity
    host_wr(2, 8'h3C);
    cnt = 0;
    for (int n = 0; n < int'(frame_len(4, 8, PAR_EVEN, 1)) + 20; n++) begin
      cnt += int'(c_rdc);
      tick(1);
    end
    chk("lb_rdc_pulses", cnt, 1);
    chk("lb_dout", c_dout, 8'h3C);
    chk("lb_flags", {c_rdf, c_error, c_perr, c_ovr}, 4'b1000);
    host_rd(2);
    chk("lb_rd_clears_rdf", c_rdf, 1'b0);

    // RX vector table on unit B
    for (int i = 0; i < 5; i++) begin
      send_bits(1, frame_b(vec[i].data, vec[i].par_flip, vec[i].stop), 11, 8);
      tick(12);
      chk($sformatf("rxv%0d_dout", i), b_dout, vec[i].e_dout);
      chk($sformatf("rxv%0d_flags", i), {b_rdf, b_error, b_perr, b_ovr},
          {vec[i].e_rdf, vec[i].e_err, vec[i].e_perr, vec[i].e_ovr});
      if (vec[i].rd_after) begin
        host_rd(1);
        chk($sformatf("rxv%0d_rd_clear", i), {b_rdf, b_error, b_perr, b_ovr}, 4'b0000);
        chk($sformatf("rxv%0d_dout_kept", i), b_dout, vec[i].e_dout);
      end
    end

    // Read in the completion cycle: new byte lands, overrun cleared, new perr kept
    send_bits(1, frame_b(8'h11, 1'b0, 1'b1), 11, 8);
    tick(12);
    send_bits(1, frame_b(8'h33, 1'b0, 1'b1), 11, 8);
    tick(12);
    chk("rdcomp_pre_ovr", {b_rdf, b_ovr, b_dout}, {2'b11, 8'h11});
    send_bits(1, frame_b(8'h22, 1'b1, 1'b1), 10, 8);
    found = 1'b0;
    for (int n = 0; n < 16 && !found; n++) begin
      if (b_rdc) begin
        found = 1'b1;
        b_rd = 1'b1; b_ce = 1'b1;
        tick(1);
        b_rd = 1'b0; b_ce = 1'b0;
      end else begin
        tick(1);
      end
    end
    chk("rdcomp_rdc_seen", found, 1'b1);
    chk("rdcomp_dout", b_dout, 8'h22);
    chk("rdcomp_flags", {b_rdf, b_error, b_perr, b_ovr}, 4'b1010);
    tick(12);
    host_rd(1);

    // Glitch: two low cycles must not start a frame
    b_rxd = 1'b0;
    tick(2);
    b_rxd = 1'b1;
    cnt = 0;
    for (int n = 0; n < 120; n++) begin
      cnt += int'(b_rdc);
      tick(1);
    end
    chk("glitch_no_rdc", cnt, 0);
    chk("glitch_flags", {b_rdf, b_error, b_perr, b_ovr}, 4'b0000);

    // Back-to-back TX on unit B: 0x55 then 0x0F written while busy
    exp_b2b = 11'b11000011110;
    tdf_n = 0;
    host_wr(1, 8'h55);
    for (int n = 0; n < 200; n++) begin
      txs[n] = b_txd;
      tdf_n += int'(b_tdf);
      if (n == 2) begin b_wr = 1'b1; b_ce = 1'b1; b_din = 8'h0F; end
      if (n == 3) begin b_wr = 1'b0; b_ce = 1'b0; end
      tick(1);
    end
    chk("b2b_stop_end", txs[89], 1'b1);
    chk("b2b_next_start", txs[90], 1'b0);
    for (int i = 0; i < 11; i++)
      chk($sformatf("b2b_f2_bit%0d", i), txs[93 + 8*i], exp_b2b[i]);
    chk("b2b_tdf_cycles", tdf_n, 176);

    // Reset mid-frame on unit A (TX and RX both in DATA, RX register holding an errored byte)
    send_bits(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10, 4);
    tick(12);
    chk("rstmf_pre", {a_rdf, a_error, a_dout}, {2'b11, 8'h3C});
    host_wr(0, 8'hFF);
    a_rxd = 1'b0; tick(4);
    a_rxd = 1'b1; tick(4);
    a_rxd = 1'b0; tick(4);
    chk("rstmf_busy", {a_tdf, a_txd}, 2'b11);
    a_rst = 1'b1;
    tick(1);
    a_rst = 1'b0; a_rxd = 1'b1;
    chk("rstmf_status", {a_txd, a_dbf, a_tdf, a_clk_div, a_rdf, a_rdc, a_error, a_perr, a_ovr}, 9'h100);
    chk("rstmf_dout", a_dout, 8'h00);
    tick(10);
    tx_a5_check("tx_after_rst");
    chk("rstmf_no_rx", {a_rdf, a_error}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART: transmitter and receiver in one block, with separate data in/out buses instead of a shared inout bus.
- Configurable data width, parity mode, stop bits and bit period.
- Single-entry TX holding register and RX data register, with status flags, for a host-side register interface.
- Sits between the host bus logic and the board serial pins.

Parameters:
- BAUD_DIV, 868: clk cycles per serial bit; legal range 4..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: TX stop bits, 1 or 2. RX always checks only the first stop bit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ce  in  1  chip enable; qualifies wr and rd only
- wr  in  1  write strobe; loads din into the TX holding register
- din  in  DATA_BITS  transmit data
- rd  in  1  read strobe; acknowledges receive data and clears RX flags
- dout  out  DATA_BITS  received data
- dbf  out  1  TX holding register full
- tdf  out  1  transmitter busy (frame in progress)
- clk_div  out  1  one-cycle pulse at each TX bit boundary; 0 when TX idle
- rdf  out  1  receive data available
- rdc  out  1  one-cycle pulse when a frame completes
- error  out  1  framing error, sticky until rd
- perr  out  1  parity error, sticky until rd
- ovr  out  1  overrun, sticky until rd
- Txd  out  1  serial out, idles 1
- Rxd  in  1  serial in, asynchronous

Behaviour:
- Reset (synchronous, active-high):
  - Txd=1; all flags 0; dout=0; both FSMs enter IDLE.
  - RX synchroniser flops reset to 1.
  - Reset mid-frame aborts the frame; Txd=1 from the next edge.
- TX write:
  - wr&ce with dbf=0: latch din into holding register; dbf=1 at the next edge.
  - wr&ce with dbf=1: ignored, holding register unchanged.
- TX FSM, states IDLE, START, DATA, PAR, STOP:
  - IDLE with dbf=1: copy holding register to shift register, clear dbf, enter START.
  - Net latency: Txd drops on the 2nd edge after the wr edge.
  - Each state lasts BAUD_DIV cycles, timed by a down-counter reloaded with BAUD_DIV-1; clk_div pulses when it reaches 0.
  - DATA shifts LSB first for DATA_BITS bits.
  - PAR is skipped when PARITY=0. Parity bit = XOR of data, inverted for odd.
  - STOP lasts STOP_BITS bit periods, then back to IDLE.
  - If dbf=1 at the end of STOP, the next START begins on the following cycle, with no idle bit.
  - tdf=1 in every state except IDLE.
  - Frame length = BAUD_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS).
- RX path: Rxd passes through a 2-flop synchroniser before use.
- RX FSM, states IDLE, START, DATA, PAR, STOP:
  - IDLE: sync=0 enters START; timer loads BAUD_DIV/2-1.
  - START: at timer 0, if the sample is 1, treat it as a glitch and return to IDLE with no flags set. Otherwise enter DATA.
  - DATA and PAR: sample once every BAUD_DIV cycles, i.e. mid-bit.
  - STOP: at the mid-bit sample, complete the frame:
    - rdc=1 for one cycle.
    - error |= (sample==0).
    - perr |= parity mismatch.
    - Return to IDLE immediately.
- Frame completion with rdf=0: dout gets the new data; rdf=1.
- Frame completion with rdf=1 and no rd in the same cycle: ovr=1, new data discarded, dout keeps the old value. error and perr still update.
- rd&ce: clears rdf, error, perr and ovr at the next edge.
- rd&ce in the same cycle as frame completion: completion wins. dout gets the new data, rdf stays 1, ovr is not set, and the new frame's error/perr are kept.
- With DATA_BITS<9, dout upper bits do not exist; width is exactly DATA_BITS.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- When defined:
  - Adds input port loopback (1 bit).
  - loopback=1 feeds the internal TX serial stream to the RX synchroniser input and holds the Txd pin at 1.
  - loopback=0 gives normal operation.
- When undefined: the port is absent and RX always uses Rxd.

Decomposition:
- Package uart_pkg:
  - PAR_NONE/PAR_ODD/PAR_EVEN constants.
  - TX and RX state encodings.
  - Frame-length function.
- Sub-module uart_bit_timer: loadable down-counter with a terminal-count pulse, instantiated once for TX and once for RX.

Test Plan:
- Basic TX: BAUD_DIV=4, DATA_BITS=8, PARITY=0, write 0xA5.
  - Txd = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - dbf high 1 cycle; tdf high 40 cycles; 10 clk_div pulses.
- Loopback: Txd wired to Rxd (or UART_LOOPBACK_EN with loopback=1), PARITY=2, write 0x3C.
  - One rdc pulse; dout=0x3C, rdf=1, perr=0.
  - rd&ce -> rdf=0 next cycle.
- Frame and parity errors: BAUD_DIV=8, PARITY=1.
  - Drive frame 0x81 with a wrong parity bit and stop=0 -> rdf=1, error=1, perr=1.
  - rd clears all three.
- Overrun: two back-to-back frames 0x11 then 0x22, no rd.
  - ovr=1, dout=0x11.
  - rd in the completion cycle of the second frame -> dout=0x22, ovr=0.
- Glitch and back-to-back TX: BAUD_DIV=8.
  - Rxd low for 2 cycles -> no rdc.
  - Second wr while tdf=1 -> second start bit immediately follows the stop bit.
- Reset mid-frame: assert rst during TX DATA and RX DATA.
  - Next edge: Txd=1, all flags 0, dout=0.
  - Next write transmits a clean frame.
